// File: rtl/id_ex_operand_pipe_pkg.sv
// id_ex_operand_pipe_pkg: shared encodings and constants for the ID/EX operand pipe.
//   RST_ENABLE      level of rst that clears state
//   WRITE_ENABLE    register write enable asserted
//   WRITE_DISABLE   register write enable deasserted
//   EXE_NOP_OP      aluop of a bubble
//   EXE_RES_NOP     alusel of a bubble
//   ZERO_WORD       cleared operand value
//   NOP_REG_ADDR    destination of a bubble
package id_ex_operand_pipe_pkg;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [7:0]  EXE_NOP_OP    = 8'h00;
    localparam logic [2:0]  EXE_RES_NOP   = 3'b000;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
endpackage

// File: rtl/id_ex_operand_pipe_fwd_mux.sv
// id_ex_operand_pipe_fwd_mux: resolves one source operand from immediate, $0,
// a priority scan over the forwarding sources, or the regfile.
//   read_i         operand comes from a register (else immediate)
//   addr_i         source register address
//   imm_i          immediate value
//   reg_data_i     regfile read data
//   fwd_wreg_i     per-source write enable
//   fwd_wd_i       per-source destination, source k at [k*ADDR_W +: ADDR_W]
//   fwd_wdata_i    per-source result data
//   fwd_is_load_i  per-source result not yet available
//   data_o         resolved operand
//   hazard_o       winning source is a load still in flight
module id_ex_operand_pipe_fwd_mux
    import id_ex_operand_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                      read_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic [DATA_W-1:0]         reg_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_is_load_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      hazard_o
);
    logic [DATA_W-1:0] w_data;
    logic              w_hit_load;
    logic              w_is_zero;

    // Scan from oldest to youngest so the lowest matching index is written last and wins.
    always_comb begin
        w_data     = reg_data_i;
        w_hit_load = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_wreg_i[k] && fwd_wd_i[k*ADDR_W +: ADDR_W] == addr_i) begin
                w_data     = fwd_wdata_i[k*DATA_W +: DATA_W];
                w_hit_load = fwd_is_load_i[k];
            end
        end
    end

    assign w_is_zero = addr_i == ADDR_W'(NOP_REG_ADDR);
    assign data_o    = !read_i ? imm_i : w_is_zero ? DATA_W'(ZERO_WORD) : w_data;
    assign hazard_o  = read_i && !w_is_zero && w_hit_load;
endmodule

// File: rtl/id_ex_operand_pipe.sv
// id_ex_operand_pipe: resolves both source operands with forwarding, detects
// load-use hazards and registers the result into the ID/EX pipeline register.
//   clk, rst          clock, asynchronous active-high reset
//   hold_i, flush_i   hold / clear the ID/EX register (flush wins)
//   id_*              decoded instruction, operand selects and regfile data
//   fwd_*             forwarding buses, index 0 is the youngest source
//   stallreq_o        combinational load-use stall request
//   ex_*              registered EX-stage instruction and operands
//   stall_cnt_o       saturating count of stall-request cycles
module id_ex_operand_pipe
    import id_ex_operand_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_FWD  = 2,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic                      id_valid_i,
    input  logic [ALUOP_W-1:0]        id_aluop_i,
    input  logic [ALUSEL_W-1:0]       id_alusel_i,
    input  logic [ADDR_W-1:0]         id_wd_i,
    input  logic                      id_wreg_i,
    input  logic                      reg1_read_i,
    input  logic                      reg2_read_i,
    input  logic [ADDR_W-1:0]         reg1_addr_i,
    input  logic [ADDR_W-1:0]         reg2_addr_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic [DATA_W-1:0]         reg1_data_i,
    input  logic [DATA_W-1:0]         reg2_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_is_load_i,
    output logic                      stallreq_o,
    output logic                      ex_valid_o,
    output logic [ALUOP_W-1:0]        ex_aluop_o,
    output logic [ALUSEL_W-1:0]       ex_alusel_o,
    output logic [DATA_W-1:0]         ex_reg1_o,
    output logic [DATA_W-1:0]         ex_reg2_o,
    output logic [ADDR_W-1:0]         ex_wd_o,
    output logic                      ex_wreg_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);
    logic [DATA_W-1:0]   w_op1, w_op2;
    logic                w_hz1, w_hz2;
    logic                w_ld;
    logic                r_valid, r_wreg;
    logic [ALUOP_W-1:0]  r_aluop;
    logic [ALUSEL_W-1:0] r_alusel;
    logic [DATA_W-1:0]   r_reg1, r_reg2;
    logic [ADDR_W-1:0]   r_wd;
    logic [CNT_W-1:0]    r_stall_cnt;

    id_ex_operand_pipe_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_op1 (
        .read_i(reg1_read_i), .addr_i(reg1_addr_i), .imm_i(imm_i), .reg_data_i(reg1_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
        .fwd_is_load_i(fwd_is_load_i), .data_o(w_op1), .hazard_o(w_hz1)
    );

    id_ex_operand_pipe_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_op2 (
        .read_i(reg2_read_i), .addr_i(reg2_addr_i), .imm_i(imm_i), .reg_data_i(reg2_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
        .fwd_is_load_i(fwd_is_load_i), .data_o(w_op2), .hazard_o(w_hz2)
    );

    // Masked by rst so ctrl never sees a stall from a pipe that is being cleared.
    assign stallreq_o = (rst != RST_ENABLE) && id_valid_i && (w_hz1 || w_hz2);
    // Flush and bubble share the clear values; only a clean, unflushed cycle loads ID.
    assign w_ld       = !flush_i && !stallreq_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_valid  <= 1'b0;
            r_wreg   <= WRITE_DISABLE;
            r_aluop  <= ALUOP_W'(EXE_NOP_OP);
            r_alusel <= ALUSEL_W'(EXE_RES_NOP);
            r_wd     <= ADDR_W'(NOP_REG_ADDR);
            r_reg1   <= DATA_W'(ZERO_WORD);
            r_reg2   <= DATA_W'(ZERO_WORD);
        end else if (flush_i || !hold_i) begin
            r_valid  <= w_ld && id_valid_i;
            r_wreg   <= w_ld ? (id_wreg_i && id_valid_i) : WRITE_DISABLE;
            r_aluop  <= w_ld ? id_aluop_i : ALUOP_W'(EXE_NOP_OP);
            r_alusel <= w_ld ? id_alusel_i : ALUSEL_W'(EXE_RES_NOP);
            r_wd     <= w_ld ? id_wd_i : ADDR_W'(NOP_REG_ADDR);
            r_reg1   <= w_ld ? w_op1 : DATA_W'(ZERO_WORD);
            r_reg2   <= w_ld ? w_op2 : DATA_W'(ZERO_WORD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE)
            r_stall_cnt <= '0;
        else if (stallreq_o && r_stall_cnt != {CNT_W{1'b1}})
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign ex_valid_o  = r_valid;
    assign ex_wreg_o   = r_wreg;
    assign ex_aluop_o  = r_aluop;
    assign ex_alusel_o = r_alusel;
    assign ex_wd_o     = r_wd;
    assign ex_reg1_o   = r_reg1;
    assign ex_reg2_o   = r_reg2;
    assign stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_operand_pipe.sv
// tb_id_ex_operand_pipe: directed vectors with a queued scoreboard for id_ex_operand_pipe.
module tb_id_ex_operand_pipe;
    logic        clk, rst, hold_i, flush_i, id_valid_i, id_wreg_i;
    logic [7:0]  id_aluop_i;
    logic [2:0]  id_alusel_i;
    logic [4:0]  id_wd_i, reg1_addr_i, reg2_addr_i;
    logic        reg1_read_i, reg2_read_i;
    logic [31:0] imm_i, reg1_data_i, reg2_data_i;
    logic [1:0]  fwd_wreg_i, fwd_is_load_i;
    logic [9:0]  fwd_wd_i;
    logic [63:0] fwd_wdata_i;
    logic        stallreq_o, ex_valid_o, ex_wreg_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [31:0] ex_reg1_o, ex_reg2_o;
    logic [4:0]  ex_wd_o;
    logic [3:0]  stall_cnt_o;

    typedef struct {
        logic        v, w;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [4:0]  wd;
        logic [31:0] r1, r2;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   total = 0;
    int   bad = 0;
    logic [3:0] exp_cnt = 4'd0;

    id_ex_operand_pipe #(.DATA_W(32), .ADDR_W(5), .NUM_FWD(2), .ALUOP_W(8), .ALUSEL_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_aluop_i(id_aluop_i), .id_alusel_i(id_alusel_i), .id_wd_i(id_wd_i), .id_wreg_i(id_wreg_i),
        .reg1_read_i(reg1_read_i), .reg2_read_i(reg2_read_i), .reg1_addr_i(reg1_addr_i),
        .reg2_addr_i(reg2_addr_i), .imm_i(imm_i), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
        .fwd_is_load_i(fwd_is_load_i), .stallreq_o(stallreq_o), .ex_valid_o(ex_valid_o),
        .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
        .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ex_valid", ex_valid_o, e.v);
            chk("ex_wreg", ex_wreg_o, e.w);
            chk("ex_aluop", ex_aluop_o, e.op);
            chk("ex_alusel", ex_alusel_o, e.sel);
            chk("ex_wd", ex_wd_o, e.wd);
            chk("ex_reg1", ex_reg1_o, e.r1);
            chk("ex_reg2", ex_reg2_o, e.r2);
            chk("stall_cnt", stall_cnt_o, e.cnt);
        end
    end

    function automatic exp_t ld(input logic v, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        e.v = v; e.w = v; e.op = 8'h21; e.sel = 3'd4; e.wd = 5'd3; e.r1 = r1; e.r2 = r2; e.cnt = 4'd0;
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e.v = 1'b0; e.w = 1'b0; e.op = 8'h00; e.sel = 3'd0; e.wd = 5'd0; e.r1 = 32'd0; e.r2 = 32'd0; e.cnt = 4'd0;
        return e;
    endfunction

    task automatic defaults();
        hold_i = 0; flush_i = 0; id_valid_i = 1; id_aluop_i = 8'h21; id_alusel_i = 3'd4;
        id_wd_i = 5'd3; id_wreg_i = 1; reg1_read_i = 1; reg2_read_i = 0;
        reg1_addr_i = 0; reg2_addr_i = 0; imm_i = 0; reg1_data_i = 0; reg2_data_i = 0;
        fwd_wreg_i = 0; fwd_wd_i = 0; fwd_wdata_i = 0; fwd_is_load_i = 0;
    endtask

    task automatic set_fwd(input int k, input logic we, input logic [4:0] wd, input logic [31:0] d, input logic isld);
        fwd_wreg_i[k] = we;
        fwd_wd_i[k*5 +: 5] = wd;
        fwd_wdata_i[k*32 +: 32] = d;
        fwd_is_load_i[k] = isld;
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic cyc(input logic es, input exp_t e);
        #1;
        chk("stallreq", stallreq_o, es);
        if (es && exp_cnt != 4'hF) exp_cnt++;
        e.cnt = exp_cnt;
        q.push_back(e);
        last = e;
        @(negedge clk);
    endtask

    initial begin
        defaults();
        rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_valid", ex_valid_o, 0);
        chk("rst_stallreq", stallreq_o, 0);
        rst = 0;
        @(negedge clk);
        chk("init_reg1", ex_reg1_o, 0);
        chk("init_cnt", stall_cnt_o, 0);
        // forwarding priority: src0 beats src1 beats regfile
        reg1_addr_i = 5; reg1_data_i = 32'h1;
        set_fwd(0, 1, 5, 32'hAAAA0000, 0);
        set_fwd(1, 1, 5, 32'h5555, 0);
        cyc(0, ld(1, 32'hAAAA0000, 0));
        fwd_wreg_i[0] = 0;
        cyc(0, ld(1, 32'h5555, 0));
        fwd_wreg_i[1] = 0;
        cyc(0, ld(1, 32'h1, 0));
        // $0 ignores forwarding; immediate path; operand 2 forwarding from src1
        defaults();
        reg1_addr_i = 0; reg1_data_i = 32'hDEAD;
        set_fwd(0, 1, 0, 32'hFFFF, 0);
        imm_i = 32'h00120000;
        cyc(0, ld(1, 0, 32'h00120000));
        reg2_read_i = 1; reg2_addr_i = 7; reg2_data_i = 32'h3;
        set_fwd(1, 1, 7, 32'h99, 0);
        cyc(0, ld(1, 0, 32'h99));
        // load-use on operand 1, then the load moves to src1 with data ready
        defaults();
        reg1_addr_i = 8; reg1_data_i = 32'h3;
        set_fwd(0, 1, 8, 32'hBAD, 1);
        cyc(1, bub());
        set_fwd(0, 0, 0, 0, 0);
        set_fwd(1, 1, 8, 32'h77, 0);
        cyc(0, ld(1, 32'h77, 0));
        // invalid ID with a hazard: no stall request; held anyway
        id_valid_i = 0; reg2_read_i = 1; reg2_addr_i = 9;
        set_fwd(0, 1, 9, 32'hBAD, 1);
        hold_i = 1;
        cyc(0, last);
        // invalid ID loads an invalid stage with wreg cleared
        defaults();
        id_valid_i = 0; reg1_addr_i = 9; reg1_data_i = 32'h42; imm_i = 32'h10;
        cyc(0, ld(0, 32'h42, 32'h10));
        // hazard under hold keeps outputs and still requests a stall
        defaults();
        reg1_addr_i = 4; reg1_data_i = 32'h6;
        cyc(0, ld(1, 32'h6, 0));
        set_fwd(0, 1, 4, 32'hBAD, 1);
        hold_i = 1;
        cyc(1, last);
        flush_i = 1;
        cyc(1, bub());
        defaults();
        flush_i = 1; reg1_addr_i = 4; reg1_data_i = 32'h6;
        cyc(0, bub());
        // 20 hazard cycles saturate the 4-bit counter
        defaults();
        reg2_read_i = 1; reg2_addr_i = 12;
        set_fwd(1, 1, 12, 32'hBAD, 1);
        for (int i = 0; i < 20; i++) cyc(1, bub());
        chk("cnt_sat_model", exp_cnt, 4'hF);
        // asynchronous reset mid-stream with a hazard pending
        defaults();
        reg1_addr_i = 9; reg1_data_i = 32'h1234;
        cyc(0, ld(1, 32'h1234, 0));
        set_fwd(0, 1, 9, 32'hBAD, 1);
        #1;
        chk("pre_rst_reg1", ex_reg1_o, 32'h1234);
        chk("pre_rst_stall", stallreq_o, 1);
        #1 rst = 1;
        #1;
        chk("arst_reg1", ex_reg1_o, 0);
        chk("arst_valid", ex_valid_o, 0);
        chk("arst_wreg", ex_wreg_o, 0);
        chk("arst_aluop", ex_aluop_o, 0);
        chk("arst_cnt", stall_cnt_o, 0);
        chk("arst_stallreq", stallreq_o, 0);
        @(negedge clk);
        defaults();
        rst = 0;
        exp_cnt = 0;
        reg1_addr_i = 2; reg1_data_i = 32'h5;
        cyc(0, ld(1, 32'h5, 0));
        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_pipe.md
Name: id_ex_operand_pipe

Overview:
- Next-generation decode back end: resolves source operands with N-way forwarding and registers them into the ID/EX pipeline register.
- Detects load-use hazards, requests a stall and inserts a bubble into EX.
- Sits between the decoder proper and the EX stage; consumes decoded control, regfile read data and forwarding buses from later stages.

Parameters:
DATA_W, 32, operand/data width
ADDR_W, 5, register address width
NUM_FWD, 2, number of forwarding sources; index 0 = youngest (EX), priority decreasing with index
ALUOP_W, 8, aluop field width
ALUSEL_W, 3, alusel field width
CNT_W, 16, width of stall-cycle statistics counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
hold_i  in  1  EX stage stalled by ctrl: hold ID/EX register
flush_i  in  1  clear ID/EX register (exception/branch)
id_valid_i  in  1  decoded instruction valid
id_aluop_i  in  ALUOP_W  decoded aluop
id_alusel_i  in  ALUSEL_W  decoded alusel
id_wd_i  in  ADDR_W  destination register
id_wreg_i  in  1  destination write enable
reg1_read_i, reg2_read_i  in  1 each  operand uses register (else immediate)
reg1_addr_i, reg2_addr_i  in  ADDR_W each  source register addresses
imm_i  in  DATA_W  immediate, already extended/shifted by decoder
reg1_data_i, reg2_data_i  in  DATA_W each  regfile read data
fwd_wreg_i  in  NUM_FWD  per-source write enable
fwd_wd_i  in  NUM_FWD*ADDR_W  per-source destination, source k at [k*ADDR_W +: ADDR_W]
fwd_wdata_i  in  NUM_FWD*DATA_W  per-source result data
fwd_is_load_i  in  NUM_FWD  source result not yet available (load in flight)
stallreq_o  out  1  combinational load-use stall request to ctrl
ex_valid_o  out  1  EX instruction valid
ex_aluop_o  out  ALUOP_W
ex_alusel_o  out  ALUSEL_W
ex_reg1_o, ex_reg2_o  out  DATA_W each  resolved operands
ex_wd_o  out  ADDR_W
ex_wreg_o  out  1
stall_cnt_o  out  CNT_W  saturating count of cycles with stallreq_o=1

Behaviour:
- Operand resolution, combinational, per operand n in {1,2}:
  - If reg_n_read_i=0, operand = imm_i.
  - Else if addr=0, operand = 0; no forwarding, no hazard.
  - Else scan sources k=0..NUM_FWD-1; the first k with fwd_wreg_i[k]=1 and fwd_wd_i[k]=addr wins.
  - If the winner has fwd_is_load_i[k]=1, it is a hazard.
  - Otherwise operand = fwd_wdata_i[k].
  - With no match, operand = reg_n_data_i.
- stallreq_o = id_valid_i & (hazard1 | hazard2). Combinational, same cycle. 0 during rst.
- ID/EX register updates on the clk rising edge, in priority order:
  1. rst: async clear.
  2. flush_i: clear.
  3. hold_i: retain all outputs.
  4. stallreq_o: load bubble.
  5. Otherwise: load resolved operands and control; ex_valid_o=id_valid_i; ex_wreg_o=id_wreg_i&id_valid_i.
- Clear and bubble values: ex_valid_o=0, ex_wreg_o=0, ex_aluop_o=NOP, ex_alusel_o=RES_NOP, ex_wd_o=0, ex_reg1_o=ex_reg2_o=0.
- Reset value of every registered output is the clear value; stall_cnt_o resets to 0.
- Latency: one cycle, ID inputs to EX outputs.
- No forward of an invalid ID instruction's own result. When id_valid_i=0, stallreq_o=0 and the loaded stage is invalid with wreg 0.
- Simultaneous events:
  - flush_i with hold_i: flush wins.
  - hold_i with hazard: register holds; stallreq_o still asserted.
- Hazard resolution: the load must advance past the sources flagged is_load; ID inputs are not latched while stalled. Ctrl holds PC/IF/ID on stallreq_o.
- stall_cnt_o increments by 1 each cycle stallreq_o=1 and saturates at all-ones. It is not cleared by flush_i.
- Reset mid-operation: all state clears immediately (async); the pending hazard is dropped.

Decomposition:
- Shared package/defines: aluop/alusel encodings (NOP, RES_NOP), ZeroWord, RstEnable, WriteEnable/Disable, NOPRegAddr.
- Sub-module fwd_mux: one operand's priority scan over NUM_FWD sources, outputs data and hazard. Instantiated twice.

Test Plan:
1. rst=1 mid-stream, with ex_reg1_o=0x1234 -> all outputs 0 asynchronously, stall_cnt_o=0, stallreq_o=0.
2. Forwarding priority: r5 read, src0 {wreg=1, wd=5, data=0xAAAA0000}, src1 {wd=5, data=0x5555}, regfile=0x1 -> next cycle ex_reg1_o=0xAAAA0000. Drop src0 -> 0x5555. Drop both -> 0x1.
3. $0 and immediate: reg1 addr 0 with src0 wd=0 wreg=1 data=0xFFFF -> ex_reg1_o=0. reg2_read=0, imm=0x00120000 -> ex_reg2_o=0x00120000.
4. Load-use: src0 {wd=8, is_load=1}, ID reads r8 -> stallreq_o=1 same cycle, next cycle ex_valid_o=0/ex_wreg_o=0. Load moves to src1 with is_load=0, data=0x77 -> stallreq_o=0, ex_reg1_o=0x77. stall_cnt_o=1.
5. Precedence: hazard with hold_i=1 -> outputs unchanged, stallreq_o=1. flush_i=1 with hold_i=1 -> clear.
6. Saturation: CNT_W=4, 20 hazard cycles -> stall_cnt_o=0xF.
